rca_lsq: RTL

- Responder end of the OU load/store request interface.
- Accepts requests from a reconfigurable OU (addr, data, fn3, load, store, new_request) and buffers them in an in-order queue.
- Issues them one at a time to a single-port data memory interface.
- Returns formatted load data to the OU as load_data with a one-cycle load_complete pulse.
- Sits between the RCA OU array and the data memory arbiter.

---
 rtl/rca_config.sv | 32 +++
 rtl/rca_lsq_fifo.sv | 65 ++++++
 rtl/rca_lsq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rca_config.sv
// Shared configuration for the RCA load/store path.
// Contents:
//   XLEN, LSQ_DEPTH      - datapath width and queue depth
//   LS_B .. LS_HU        - RISC-V funct3 encodings for load/store width
//   lsq_req_t            - one queued request as captured from the OU
//   lsq_state_t          - issue FSM states of the LSQ
package rca_config;

  localparam int XLEN      = 32;
  localparam int LSQ_DEPTH = 4;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
  } lsq_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOAD
  } lsq_state_t;

endpackage

// File: rtl/rca_lsq_fifo.sv
// In-order circular buffer of lsq_req_t entries.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_req  - write push_req at the tail (ignored when full)
//   pop             - retire the head entry (ignored when empty)
//   head            - entry at the head of the queue
//   count           - number of valid entries (0..DEPTH)
//   full, empty     - occupancy flags derived from count
module rca_lsq_fifo
  import rca_config::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  lsq_req_t               push_req,
  input  logic                   pop,
  output lsq_req_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  lsq_req_t        entries [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  // NOTE: storage has no reset; entries are only read once count says they
  // were written, so clearing them would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_req;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rca_lsq.sv
// Load/store queue: responder end of the OU load/store request interface.
// Buffers OU requests in order and issues them one at a time to a
// single-port data memory; load results come back formatted on load_data
// with a one-cycle load_complete pulse.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   addr, data, fn3, load, store,
//   new_request                       - OU request (load XOR store required)
//   lsq_full                          - queue full, OU must hold off
//   load_data, load_complete          - formatted load result + valid pulse
//   mem_addr, mem_wdata, mem_be,
//   mem_re, mem_we, mem_ready         - memory request, held until mem_ready
//   mem_rdata, mem_rvalid             - memory read return
module rca_lsq
  import rca_config::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_re,
  output logic            mem_we,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
);

  localparam int CW = $clog2(LSQ_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(LSQ_DEPTH);

  lsq_state_t      state;
  lsq_state_t      state_nxt;
  lsq_req_t        in_req;
  lsq_req_t        head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            iss_load;
  logic [2:0]      iss_fn3;
  logic [1:0]      iss_off;

  // Store data is replicated across lanes; byte enables pick the lane.
  function automatic logic [XLEN-1:0] fmt_wdata(input logic [XLEN-1:0] d,
                                                input logic [2:0] f);
    case (f[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] fmt_be(input logic [2:0] f,
                                        input logic [1:0] off);
    case (f[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Misaligned halfword/word offsets are simply ignored.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rd,
                                               input logic [2:0] f,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f)
      LS_B:    return {{(XLEN-8){b[7]}}, b};
      LS_BU:   return {{(XLEN-8){1'b0}}, b};
      LS_H:    return {{(XLEN-16){h[15]}}, h};
      LS_HU:   return {{(XLEN-16){1'b0}}, h};
      default: return rd;
    endcase
  endfunction

  assign in_req = '{addr: addr, data: data, fn3: fn3, load: load, store: store};
  assign push   = new_request && !fifo_full && (load ^ store);
  assign lsq_full = (fifo_count == CNT_FULL);

  rca_lsq_fifo #(.DEPTH(LSQ_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (in_req),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) state_nxt = iss_load ? WAIT_LOAD : IDLE;
      end
      WAIT_LOAD: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers are loaded when the head is popped and held
  // untouched until the memory accepts; only one operation is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      iss_load      <= 1'b0;
      iss_fn3       <= '0;
      iss_off       <= '0;
      load_data     <= '0;
      load_complete <= 1'b0;
    end else begin
      load_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            mem_addr  <= {head.addr[XLEN-1:2], 2'b00};
            mem_wdata <= fmt_wdata(head.data, head.fn3);
            mem_be    <= head.load ? 4'b1111 : fmt_be(head.fn3, head.addr[1:0]);
            mem_re    <= head.load;
            mem_we    <= head.store;
            iss_load  <= head.load;
            iss_fn3   <= head.fn3;
            iss_off   <= head.addr[1:0];
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            load_data     <= fmt_load(mem_rdata, iss_fn3, iss_off);
            load_complete <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
